// File: rtl/ddio_in_pkg.sv
// Shared constants for the DDR input capture block.
// Keeps the default lane count in one place for the top and any wrappers.
package ddio_in_pkg;

    localparam int DDIO_IN_DEFAULT_WIDTH = 8;

endpackage : ddio_in_pkg

// File: rtl/ddio_in_bit.sv
// Single-lane DDR capture cell: falling-edge capture plus two rising-edge registers.
// The falling-edge sample is re-timed so both outputs move only on the rising edge.
module ddio_in_bit (
    input  logic i_inclock,
    input  logic i_aclr,
    input  logic i_datain,
    output logic o_dataout_h,
    output logic o_dataout_l
);

    logic r_negCap;
    logic r_hReg;
    logic r_lReg;

    always_ff @(negedge i_inclock or posedge i_aclr) begin
        if (i_aclr) begin
            r_negCap <= 1'b0;
        end else begin
            r_negCap <= i_datain;
        end
    end

    // r_lReg holds the older (falling-edge) bit so {l, h} is chronological
    always_ff @(posedge i_inclock or posedge i_aclr) begin
        if (i_aclr) begin
            r_hReg <= 1'b0;
            r_lReg <= 1'b0;
        end else begin
            r_hReg <= i_datain;
            r_lReg <= r_negCap;
        end
    end

    assign o_dataout_h = r_hReg;
    assign o_dataout_l = r_lReg;

endmodule : ddio_in_bit

// File: rtl/ddio_in.sv
// DDR input capture register for the ADC LVDS data lanes.
// No synchroniser on datain: it is source-synchronous and extra stages would break DDR alignment.
module ddio_in
    import ddio_in_pkg::*;
#(
    parameter int WIDTH = DDIO_IN_DEFAULT_WIDTH
) (
    input  logic             inclock,
    input  logic             aclr,
    input  logic [WIDTH-1:0] datain,
    output logic [WIDTH-1:0] dataout_h,
    output logic [WIDTH-1:0] dataout_l
);

    for (genvar g = 0; g < WIDTH; g++) begin : g_lane
        ddio_in_bit u_bit (
            .i_inclock   (inclock),
            .i_aclr      (aclr),
            .i_datain    (datain[g]),
            .o_dataout_h (dataout_h[g]),
            .o_dataout_l (dataout_l[g])
        );
    end

endmodule : ddio_in

// File: tb/tb_ddio_in.sv
// Directed self-checking bench for ddio_in: reset, static data, DDR ordering,
// lane independence, reset release between edges and serial word reassembly.
module tb_ddio_in;

    logic       inclock;
    logic       aclr;
    logic [7:0] datain;
    logic [7:0] dataout_h;
    logic [7:0] dataout_l;

    int checks;
    int errors;

    ddio_in #(.WIDTH(8)) dut (
        .inclock   (inclock),
        .aclr      (aclr),
        .datain    (datain),
        .dataout_h (dataout_h),
        .dataout_l (dataout_l)
    );

    // Rising edges at 5, 15, 25 ...; falling edges at 10, 20, 30 ...
    initial begin
        inclock = 1'b0;
        forever #5 inclock = ~inclock;
    end

    task automatic applyStimulus(input logic [7:0] d);
        datain = d;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    logic [11:0] word;
    logic [11:0] rebuilt;

    initial begin
        checks  = 0;
        errors  = 0;
        aclr    = 1'b1;
        applyStimulus(8'hFF);
        word    = 12'hB4D;
        rebuilt = 12'h000;

        // Reset held while the clock toggles with all-ones data
        for (int i = 0; i < 3; i++) begin
            @(posedge inclock); #1;
            checkOutput("rst_h", dataout_h, 8'h00);
            checkOutput("rst_l", dataout_l, 8'h00);
        end

        // Release after a falling edge with static 0xA5
        @(negedge inclock); #1;
        applyStimulus(8'hA5);
        aclr = 1'b0;
        @(posedge inclock); #1;
        checkOutput("static_first_h", dataout_h, 8'hA5);
        checkOutput("static_first_l", dataout_l, 8'h00);
        for (int i = 0; i < 2; i++) begin
            @(posedge inclock); #1;
            checkOutput("static_h", dataout_h, 8'hA5);
            checkOutput("static_l", dataout_l, 8'hA5);
        end

        // Asynchronous clear between edges
        #1;
        aclr = 1'b1;
        #1;
        checkOutput("async_clr_h", dataout_h, 8'h00);
        checkOutput("async_clr_l", dataout_l, 8'h00);

        // Reset release between edges with 0x3C
        @(negedge inclock); #1;
        applyStimulus(8'h3C);
        aclr = 1'b0;
        @(posedge inclock); #1;
        checkOutput("rel_first_h", dataout_h, 8'h3C);
        checkOutput("rel_first_l", dataout_l, 8'h00);
        @(posedge inclock); #1;
        checkOutput("rel_second_h", dataout_h, 8'h3C);
        checkOutput("rel_second_l", dataout_l, 8'h3C);

        // DDR ordering: 0x0F around falling edges, 0xF0 around rising edges
        applyStimulus(8'h0F);
        for (int i = 0; i < 4; i++) begin
            @(negedge inclock); #1;
            applyStimulus(8'hF0);
            @(posedge inclock); #1;
            checkOutput("ddr_h", dataout_h, 8'hF0);
            checkOutput("ddr_l", dataout_l, 8'h0F);
            applyStimulus(8'h0F);
        end

        // Lane independence: only lane 3 toggles
        applyStimulus(8'h08);
        for (int i = 0; i < 3; i++) begin
            @(negedge inclock); #1;
            applyStimulus(8'h00);
            @(posedge inclock); #1;
            checkOutput("lane3_h", dataout_h, 8'h00);
            checkOutput("lane3_l", dataout_l, 8'h08);
            applyStimulus(8'h08);
        end

        // Serial reassembly of a 12-bit word on lane 0, MSB first
        applyStimulus({7'b0, word[11]});
        for (int k = 0; k < 6; k++) begin
            @(negedge inclock); #1;
            applyStimulus({7'b0, word[10 - 2*k]});
            @(posedge inclock); #1;
            rebuilt = {rebuilt[9:0], dataout_l[0], dataout_h[0]};
            if (k < 5) begin
                applyStimulus({7'b0, word[9 - 2*k]});
            end
        end
        checks++;
        assert (rebuilt === 12'hB4D) else begin
            errors++;
            $error("[TB] FAIL serial_word observed=%h expected=%h", rebuilt, 12'hB4D);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ddio_in
